// File: rtl/dm_ext.sv
// dm_ext -- byte-addressable data memory with load/store extension, fault
// detection and a small store trace.
//
// Word-organised storage of DEPTH_WORDS 32-bit words, little-endian lanes.
// Loads are combinational (no latency); stores commit on the rising edge.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   WE, RE        store / load request this cycle (RE only qualifies AdEL)
//   Mode          000 word, 001 half u, 010 half s, 011 byte u, 100 byte s
//   A, WD, pc     byte address, store data, issuing PC (trace only)
//   RD            extended load data, 0 on any faulting access
//   AdEL, AdES    combinational load / store fault flags
//   err_sticky    a fault has been seen since reset
//   wr_count      committed stores, saturating at all-ones
//   last_pc/last_addr/last_data  trace of the last committed store
module dm_ext #(
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE,
  input  logic              RE,
  input  logic [2:0]        Mode,
  input  logic [31:0]       A,
  input  logic [31:0]       WD,
  input  logic [31:0]       pc,
  output logic [31:0]       RD,
  output logic              AdEL,
  output logic              AdES,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  wr_count,
  output logic [31:0]       last_pc,
  output logic [31:0]       last_addr,
  output logic [31:0]       last_data
);

  localparam logic [2:0] M_WORD = 3'b000;
  localparam logic [2:0] M_HU   = 3'b001;
  localparam logic [2:0] M_HS   = 3'b010;
  localparam logic [2:0] M_BU   = 3'b011;
  localparam logic [2:0] M_BS   = 3'b100;

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 33-bit limit so 4*DEPTH_WORDS never overflows the compare.
  localparam logic [32:0] LIMIT = 33'(64'(DEPTH_WORDS) * 64'd4);

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [AW-1:0]    word_idx;
  logic             in_range;
  logic             misalign;
  logic             fault;
  logic [31:0]      rd_word;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [31:0]      merged;
  logic             commit;

  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [31:0]      last_addr_q, last_addr_d;
  logic [31:0]      last_data_q, last_data_d;

  assign word_idx = A[AW+1:2];
  assign in_range = ({1'b0, A} < LIMIT);

  always_comb begin
    misalign = 1'b0;
    case (Mode)
      M_WORD:       misalign = (A[1:0] != 2'b00);
      M_HU, M_HS:   misalign = A[0];
      M_BU, M_BS:   misalign = 1'b0;
      default:      misalign = 1'b1;
    endcase
  end

  assign fault = !in_range || misalign;
  assign AdES  = WE && fault;
  assign AdEL  = RE && fault;

  // Guard the array read so out-of-range indices never reach the memory.
  assign rd_word = in_range ? mem_q[word_idx] : 32'h0;
  assign byte_v  = rd_word[{A[1:0], 3'b000} +: 8];
  assign half_v  = rd_word[{A[1], 4'b0000} +: 16];

  always_comb begin
    RD = 32'h0;
    case (Mode)
      M_WORD:  RD = rd_word;
      M_HU:    RD = {16'h0, half_v};
      M_HS:    RD = {{16{half_v[15]}}, half_v};
      M_BU:    RD = {24'h0, byte_v};
      M_BS:    RD = {{24{byte_v[7]}}, byte_v};
      default: RD = 32'h0;
    endcase
    if (fault) RD = 32'h0;
  end

  // Read-modify-write: only the addressed lanes of the current word change.
  always_comb begin
    merged = rd_word;
    case (Mode)
      M_WORD:      merged = WD;
      M_HU, M_HS:  merged[{A[1], 4'b0000} +: 16] = WD[15:0];
      M_BU, M_BS:  merged[{A[1:0], 3'b000} +: 8] = WD[7:0];
      default:     merged = rd_word;
    endcase
  end

  assign commit = WE && !fault && !reset;

  always_comb begin
    err_sticky_d = err_sticky_q | AdEL | AdES;
    wr_count_d   = wr_count_q;
    last_pc_d    = last_pc_q;
    last_addr_d  = last_addr_q;
    last_data_d  = last_data_q;
    if (commit) begin
      if (wr_count_q != {CNT_W{1'b1}}) wr_count_d = wr_count_q + 1'b1;
      last_pc_d   = pc;
      last_addr_d = {A[31:2], 2'b00};
      last_data_d = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem_q[i] <= 32'h0;
    end else if (commit) begin
      mem_q[word_idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
      wr_count_q   <= '0;
      last_pc_q    <= 32'h0;
      last_addr_q  <= 32'h0;
      last_data_q  <= 32'h0;
    end else begin
      err_sticky_q <= err_sticky_d;
      wr_count_q   <= wr_count_d;
      last_pc_q    <= last_pc_d;
      last_addr_q  <= last_addr_d;
      last_data_q  <= last_data_d;
    end
  end

  assign err_sticky = err_sticky_q;
  assign wr_count   = wr_count_q;
  assign last_pc    = last_pc_q;
  assign last_addr  = last_addr_q;
  assign last_data  = last_data_q;

endmodule

// File: tb/tb_dm_ext.sv
// tb_dm_ext -- directed bench for dm_ext: default-size instance for the main
// checks, plus a small CNT_W=2 instance for counter saturation.
module tb_dm_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE, RE, WE2;
  logic [2:0]  Mode;
  logic [31:0] A, WD, pc;

  logic [31:0] RD, last_pc, last_addr, last_data;
  logic        AdEL, AdES, err_sticky;
  logic [15:0] wr_count;

  logic [31:0] RD2, last_pc2, last_addr2, last_data2;
  logic        AdEL2, AdES2, err_sticky2;
  logic [1:0]  wr_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_ext u_dut (
    .clk(clk), .reset(reset), .WE(WE), .RE(RE), .Mode(Mode), .A(A), .WD(WD),
    .pc(pc), .RD(RD), .AdEL(AdEL), .AdES(AdES), .err_sticky(err_sticky),
    .wr_count(wr_count), .last_pc(last_pc), .last_addr(last_addr),
    .last_data(last_data)
  );

  dm_ext #(.DEPTH_WORDS(16), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .WE(WE2), .RE(RE), .Mode(Mode), .A(A), .WD(WD),
    .pc(pc), .RD(RD2), .AdEL(AdEL2), .AdES(AdES2), .err_sticky(err_sticky2),
    .wr_count(wr_count2), .last_pc(last_pc2), .last_addr(last_addr2),
    .last_data(last_data2)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [2:0] m,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] p);
    WE = we; RE = re; Mode = m; A = a; WD = wd; pc = p;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, 1'b1, m, a, 32'h0, 32'h0);
    chk_eq(tag, RD, exp);
  endtask

  initial begin
    reset = 1'b1; WE2 = 1'b0;
    idle();
    step(); step();
    reset = 1'b0;
    #1;

    // Reset state
    chk_eq("rst_wr_count", 32'(wr_count), 32'h0);
    chk_eq("rst_err", 32'(err_sticky), 32'h0);
    chk_eq("rst_last_data", last_data, 32'h0);
    rd_chk("rst_word10", 3'b000, 32'h10, 32'h0);

    // Word store then signed/unsigned byte loads
    drive(1'b1, 1'b0, 3'b000, 32'h10, 32'h80FF7F01, 32'h100);
    chk_eq("st1_ades", 32'(AdES), 32'h0);
    step();
    idle();
    chk_eq("st1_count", 32'(wr_count), 32'd1);
    chk_eq("st1_last_pc", last_pc, 32'h100);
    chk_eq("st1_last_addr", last_addr, 32'h10);
    chk_eq("st1_last_data", last_data, 32'h80FF7F01);
    rd_chk("ld_13_bs", 3'b100, 32'h13, 32'hFFFFFF80);
    rd_chk("ld_11_bu", 3'b011, 32'h11, 32'h0000007F);
    rd_chk("ld_10_bs", 3'b100, 32'h10, 32'h00000001);
    rd_chk("ld_12_bs", 3'b100, 32'h12, 32'hFFFFFFFF);

    // Upper half merge
    drive(1'b1, 1'b0, 3'b001, 32'h12, 32'h1234ABCD, 32'h104);
    step();
    idle();
    chk_eq("hs_last_data", last_data, 32'hABCD7F01);
    chk_eq("hs_last_addr", last_addr, 32'h10);
    chk_eq("hs_count", 32'(wr_count), 32'd2);
    rd_chk("hs_word", 3'b000, 32'h10, 32'hABCD7F01);
    rd_chk("hs_ld_hs", 3'b010, 32'h12, 32'hFFFFABCD);
    rd_chk("hs_ld_hu", 3'b001, 32'h12, 32'h0000ABCD);
    rd_chk("hs_ld_lo_hs", 3'b010, 32'h10, 32'h00007F01);

    // Same-word load and store: pre-edge data before, post-edge after
    drive(1'b1, 1'b1, 3'b011, 32'h11, 32'hAAAAAA55, 32'h108);
    chk_eq("rw_pre", RD, 32'h0000007F);
    chk_eq("rw_adel", 32'(AdEL), 32'h0);
    step();
    chk_eq("rw_post", RD, 32'h00000055);
    idle();
    rd_chk("rw_word", 3'b000, 32'h10, 32'hABCD5501);
    chk_eq("rw_count", 32'(wr_count), 32'd3);

    // Misaligned word store
    drive(1'b1, 1'b0, 3'b000, 32'h6, 32'h11111111, 32'h10C);
    chk_eq("mis_ades", 32'(AdES), 32'h1);
    chk_eq("mis_adel_noRE", 32'(AdEL), 32'h0);
    chk_eq("mis_rd", RD, 32'h0);
    chk_eq("mis_err_pre", 32'(err_sticky), 32'h0);
    step();
    idle();
    chk_eq("mis_err", 32'(err_sticky), 32'h1);
    chk_eq("mis_count", 32'(wr_count), 32'd3);
    chk_eq("mis_last_pc", last_pc, 32'h108);
    chk_eq("mis_last_data", last_data, 32'hABCD5501);
    rd_chk("mis_word4", 3'b000, 32'h4, 32'h0);

    // Misaligned half, illegal mode, and WE+RE independent checks
    drive(1'b1, 1'b1, 3'b010, 32'h11, 32'h0, 32'h0);
    chk_eq("mh_adel", 32'(AdEL), 32'h1);
    chk_eq("mh_ades", 32'(AdES), 32'h1);
    idle();
    rd_chk("ill_mode_rd", 3'b101, 32'h10, 32'h0);
    chk_eq("ill_mode_adel", 32'(AdEL), 32'h1);
    chk_eq("ill_mode_ades", 32'(AdES), 32'h0);

    // Range boundary
    rd_chk("oor_rd", 3'b000, 32'h3000, 32'h0);
    chk_eq("oor_adel", 32'(AdEL), 32'h1);
    rd_chk("oor_byte", 3'b011, 32'h3000, 32'h0);
    chk_eq("oor_byte_adel", 32'(AdEL), 32'h1);
    drive(1'b1, 1'b0, 3'b000, 32'h2FFC, 32'hCAFEF00D, 32'h110);
    chk_eq("top_ades", 32'(AdES), 32'h0);
    step();
    idle();
    rd_chk("top_rd", 3'b000, 32'h2FFC, 32'hCAFEF00D);
    chk_eq("top_adel", 32'(AdEL), 32'h0);
    rd_chk("top_b3", 3'b100, 32'h2FFF, 32'hFFFFFFCA);
    chk_eq("top_count", 32'(wr_count), 32'd4);
    drive(1'b1, 1'b0, 3'b011, 32'h3000, 32'h77, 32'h114);
    chk_eq("oor_ades", 32'(AdES), 32'h1);
    step();
    idle();
    chk_eq("oor_st_count", 32'(wr_count), 32'd4);

    // Reset beats a simultaneous store
    reset = 1'b1;
    drive(1'b1, 1'b0, 3'b000, 32'h0, 32'hDEADBEEF, 32'h200);
    step();
    // Fault flags stay live during reset, but err_sticky must not latch
    drive(1'b1, 1'b0, 3'b000, 32'h6, 32'h0, 32'h0);
    chk_eq("rst_ades_live", 32'(AdES), 32'h1);
    step();
    chk_eq("rst_err_hold", 32'(err_sticky), 32'h0);
    reset = 1'b0;
    idle();
    rd_chk("rst_word0", 3'b000, 32'h0, 32'h0);
    rd_chk("rst_word10b", 3'b000, 32'h10, 32'h0);
    rd_chk("rst_top", 3'b000, 32'h2FFC, 32'h0);
    chk_eq("rst2_count", 32'(wr_count), 32'h0);
    chk_eq("rst2_err", 32'(err_sticky), 32'h0);
    chk_eq("rst2_last_pc", last_pc, 32'h0);
    chk_eq("rst2_last_addr", last_addr, 32'h0);
    chk_eq("rst2_last_data", last_data, 32'h0);

    // Saturating counter on the CNT_W=2 instance
    chk_eq("sat_rst", 32'(wr_count2), 32'h0);
    for (int i = 0; i < 5; i++) begin
      WE2 = 1'b1;
      drive(1'b0, 1'b0, 3'b000, 32'(i * 4), 32'(i + 1), 32'h300);
      step();
      WE2 = 1'b0;
      #1;
      chk_eq($sformatf("sat_%0d", i), 32'(wr_count2), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    chk_eq("sat_last_data", last_data2, 32'd5);
    chk_eq("sat_main_untouched", 32'(wr_count), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
